// File: rtl/mant_mul_pkg.sv
// Shared types, bounds and helpers for the mantissa multiplier.
// Ports: none (package only).
package mant_mul_pkg;

    typedef enum logic {
        RM_TRUNC = 1'b0,
        RM_RNE   = 1'b1
    } round_mode_e;

    localparam int W_MIN      = 4;
    localparam int W_MAX      = 24;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 3;

    // Row count after lvl levels of 3:2 compression of w rows.
    function automatic int mm_rows(input int w, input int lvl);
        int n;
        n = w;
        for (int i = 0; i < lvl; i++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    // Levels needed to bring w rows down to two.
    function automatic int mm_levels(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/mant_mul_reduce.sv
// Wallace 3:2 reduction of W x W partial products to sum/carry.
// Ports: a, b (W-bit operands) -> sum, carry (2W-bit, sum+carry = a*b).
module mant_mul_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module mant_mul_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    mant_mul_ha u_h0 (.a(a),  .b(b),  .s(s1), .c(c1));
    mant_mul_ha u_h1 (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

module mant_mul_reduce
    import mant_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] sum,
    output logic [2*W-1:0] carry
);
    localparam int LV = mm_levels(W);
    localparam int PW = 2 * W;

    logic [PW-1:0] r [LV+1][W];

    for (genvar i = 0; i < W; i++) begin : g_pp
        assign r[0][i] = {{W{1'b0}}, a & {W{b[i]}}} << i;
    end

    for (genvar l = 1; l <= LV; l++) begin : g_lv
        localparam int NP = mm_rows(W, l - 1);
        localparam int G  = NP / 3;
        localparam int N  = mm_rows(W, l);

        for (genvar j = 0; j < G; j++) begin : g_csa
            logic [PW-1:0] s;
            logic [PW-2:0] c;

            for (genvar k = 0; k < PW - 1; k++) begin : g_bit
                mant_mul_fa u_fa (
                    .a (r[l-1][3*j][k]),
                    .b (r[l-1][3*j+1][k]),
                    .ci(r[l-1][3*j+2][k]),
                    .s (s[k]),
                    .co(c[k])
                );
            end

            // Carry out of the top column falls outside the 2W-bit
            // product and can never be set by a real a*b.
            assign s[PW-1] = r[l-1][3*j][PW-1]
                           ^ r[l-1][3*j+1][PW-1]
                           ^ r[l-1][3*j+2][PW-1];

            assign r[l][2*j]   = s;
            assign r[l][2*j+1] = {c, 1'b0};
        end

        for (genvar j = 3 * G; j < NP; j++) begin : g_pass
            assign r[l][j-G] = r[l-1][j];
        end

        for (genvar j = N; j < W; j++) begin : g_pad
            assign r[l][j] = '0;
        end
    end

    assign sum   = r[LV][0];
    assign carry = r[LV][1];
endmodule

// File: rtl/mant_mul_pipe.sv
// Pipelined mantissa multiplier: normalise, truncate/RNE round.
// Ports: clk, rst, flush; in_valid/in_ready, in_a, in_b, in_rne,
//   in_tag; out_valid/out_ready, out_mant, out_exp_inc,
//   out_inexact, out_zero, out_tag.
module mant_mul_pipe
    import mant_mul_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_rne,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_mant,
    output logic             out_exp_inc,
    output logic             out_inexact,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int L  = STAGES - 1;
    localparam int PW = 2 * W;
    localparam int RW = W + 3;

    if (W < W_MIN || W > W_MAX ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad
        $error("mant_mul_pipe: W or STAGES out of range");
    end

    // Result packing: {mant, exp_inc, inexact, zero}.
    function automatic logic [RW-1:0] round_p(
        input logic [PW-1:0] p,
        input logic          rne
    );
        logic          ovf;
        logic [W-1:0]  m;
        logic          g;
        logic          s;
        logic          up;
        logic [W:0]    mr;
        logic          rc;
        logic [W-1:0]  mo;
        round_mode_e   rm;

        rm  = round_mode_e'(rne);
        ovf = p[PW-1];
        if (ovf) begin
            m = p[PW-1:W];
            g = p[W-1];
            s = |p[W-2:0];
        end else begin
            m = p[PW-2:W-1];
            g = p[W-2];
            s = |p[W-3:0];
        end
        up = (rm == RM_RNE) & g & (s | m[0]);
        mr = {1'b0, m} + {{W{1'b0}}, up};
        rc = mr[W];
        mo = rc ? {1'b1, {(W-1){1'b0}}} : mr[W-1:0];
        return {mo, ovf | rc, g | s, p == '0};
    endfunction

    logic [L:0] vld;
    logic [L:0] go;
    logic [L:0] en;
    logic       acc;

    // go[i]: stage i may load this cycle (empty or draining).
    always_comb begin
        go    = '0;
        go[L] = ~vld[L] | out_ready;
        for (int i = L - 1; i >= 0; i--) begin
            go[i] = ~vld[i] | go[i+1];
        end
    end

    assign in_ready = go[0] & ~flush;
    assign acc      = in_valid & in_ready;

    always_comb begin
        en    = '0;
        en[0] = acc;
        for (int i = 1; i <= L; i++) begin
            en[i] = go[i] & vld[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            if (go[0]) vld[0] <= acc;
            for (int i = 1; i <= L; i++) begin
                if (go[i]) vld[i] <= vld[i-1];
            end
        end
    end

    logic [PW-1:0]    rs;
    logic [PW-1:0]    rcv;
    logic [RW-1:0]    res_d;
    logic [TAG_W-1:0] tag_d;

    mant_mul_reduce #(.W(W)) u_red (
        .a    (in_a),
        .b    (in_b),
        .sum  (rs),
        .carry(rcv)
    );

    if (STAGES == 1) begin : g_s1
        assign res_d = round_p(rs + rcv, in_rne);
        assign tag_d = in_tag;
    end else if (STAGES == 2) begin : g_s2
        logic [PW-1:0]    p_q;
        logic             rne_q;
        logic [TAG_W-1:0] t_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_q   <= '0;
                rne_q <= 1'b0;
                t_q   <= '0;
            end else if (en[0]) begin
                p_q   <= rs + rcv;
                rne_q <= in_rne;
                t_q   <= in_tag;
            end
        end

        assign res_d = round_p(p_q, rne_q);
        assign tag_d = t_q;
    end else begin : g_s3
        logic [PW-1:0]    s_q;
        logic [PW-1:0]    c_q;
        logic             rne0;
        logic [TAG_W-1:0] t0;
        logic [PW-1:0]    p_q;
        logic             rne1;
        logic [TAG_W-1:0] t1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q  <= '0;
                c_q  <= '0;
                rne0 <= 1'b0;
                t0   <= '0;
            end else if (en[0]) begin
                s_q  <= rs;
                c_q  <= rcv;
                rne0 <= in_rne;
                t0   <= in_tag;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_q  <= '0;
                rne1 <= 1'b0;
                t1   <= '0;
            end else if (en[1]) begin
                p_q  <= s_q + c_q;
                rne1 <= rne0;
                t1   <= t0;
            end
        end

        assign res_d = round_p(p_q, rne1);
        assign tag_d = t1;
    end

    logic [RW-1:0]    res_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            tag_q <= '0;
        end else if (en[L]) begin
            res_q <= res_d;
            tag_q <= tag_d;
        end
    end

    assign out_valid   = vld[L];
    assign out_mant    = res_q[RW-1:3];
    assign out_exp_inc = res_q[2];
    assign out_inexact = res_q[1];
    assign out_zero    = res_q[0];
    assign out_tag     = tag_q;
endmodule

// File: tb/tb_mant_mul_pipe.sv
// Self-checking bench: three DUTs (STAGES=1,2,3), W=8.
// Ports: none (top-level bench).
module tb_mant_mul_pipe;
    localparam int W  = 8;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          iv   [3];
    logic          ir   [3];
    logic [W-1:0]  ia   [3];
    logic [W-1:0]  ib   [3];
    logic          irne [3];
    logic [TW-1:0] itag [3];
    logic          ordy [3];
    logic          fl   [3];
    logic          ov   [3];
    logic [W-1:0]  om   [3];
    logic          oe   [3];
    logic          ox   [3];
    logic          oz   [3];
    logic [TW-1:0] ot   [3];

    typedef struct packed {
        logic [7:0] m;
        logic       e;
        logic       x;
        logic       z;
        logic [3:0] t;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: split P into kept value and remainder, compare
    // remainder against one half-ulp.
    function automatic exp_t model(input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic rne,
                                   input logic [3:0] t);
        exp_t        r;
        int unsigned p, sh, m, rem, half;
        p    = 32'(a) * 32'(b);
        sh   = (p >= 32'h8000) ? 8 : 7;
        m    = p >> sh;
        rem  = p & ((32'd1 << sh) - 1);
        half = 32'd1 << (sh - 1);
        r.e  = (sh == 8);
        r.x  = (rem != 0);
        r.z  = (p == 0);
        if (rne && (rem > half || (rem == half && (m % 2) == 1)))
            m = m + 1;
        if (m == 256) begin
            m   = 128;
            r.e = 1'b1;
        end
        r.m = m[7:0];
        r.t = t;
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mant_mul_pipe #(.W(W), .STAGES(g + 1), .TAG_W(TW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .flush      (fl[g]),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .in_a       (ia[g]),
            .in_b       (ib[g]),
            .in_rne     (irne[g]),
            .in_tag     (itag[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .out_mant   (om[g]),
            .out_exp_inc(oe[g]),
            .out_inexact(ox[g]),
            .out_zero   (oz[g]),
            .out_tag    (ot[g])
        );

        exp_t q[$];
        exp_t e;

        always @(negedge clk) begin
            if (rst || fl[g]) begin
                q.delete();
            end else begin
                if (ov[g] && ordy[g]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("s%0d_spurious", g + 1), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("s%0d_mant", g + 1),
                            32'(om[g]), 32'(e.m));
                        chk($sformatf("s%0d_exp_inc", g + 1),
                            32'(oe[g]), 32'(e.e));
                        chk($sformatf("s%0d_inexact", g + 1),
                            32'(ox[g]), 32'(e.x));
                        chk($sformatf("s%0d_zero", g + 1),
                            32'(oz[g]), 32'(e.z));
                        chk($sformatf("s%0d_tag", g + 1),
                            32'(ot[g]), 32'(e.t));
                    end
                end
                if (iv[g] && ir[g])
                    q.push_back(model(ia[g], ib[g], irne[g], itag[g]));
            end
        end
    end

    task automatic chk_zero_out(input int k, input string tag);
        chk({tag, "_ov"},   32'(ov[k]), 0);
        chk({tag, "_mant"}, 32'(om[k]), 0);
        chk({tag, "_inc"},  32'(oe[k]), 0);
        chk({tag, "_inx"},  32'(ox[k]), 0);
        chk({tag, "_zero"}, 32'(oz[k]), 0);
        chk({tag, "_tag"},  32'(ot[k]), 0);
    endtask

    // Single op into an empty pipe with out_ready=1; checks latency.
    task automatic run_vec(input int k, input logic [7:0] a,
                           input logic [7:0] b, input logic rne,
                           input logic [7:0] em, input logic ee,
                           input logic ex, input logic ez);
        bit ok;
        int n;
        @(posedge clk); #1;
        iv[k] = 1'b1; ia[k] = a; ib[k] = b;
        irne[k] = rne; itag[k] = 4'(k + 5);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir[k]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("vec_accept", 32'(ok), 1);
        @(posedge clk); #1;
        iv[k] = 1'b0;
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (ov[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("vec_seen", 32'(ok), 1);
        chk("vec_lat",  n, k + 1);
        chk("vec_mant", 32'(om[k]), 32'(em));
        chk("vec_inc",  32'(oe[k]), 32'(ee));
        chk("vec_inx",  32'(ox[k]), 32'(ex));
        chk("vec_zero", 32'(oz[k]), 32'(ez));
    endtask

    task automatic bp_test(input int k);
        int acc = 0;
        int outs = 0;
        int first = -1;
        int last = -1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            iv[k]   = (acc < 6);
            ia[k]   = 8'($urandom);
            ib[k]   = 8'($urandom);
            irne[k] = 1'($urandom);
            itag[k] = 4'(acc);
            if (cyc == 10) ordy[k] = 1'b1;
            @(negedge clk);
            if (cyc == 9) begin
                chk($sformatf("bp%0d_fill", k + 1), acc, k + 1);
                chk($sformatf("bp%0d_ir", k + 1), 32'(ir[k]), 0);
            end
            if (iv[k] && ir[k]) acc++;
            if (ov[k] && ordy[k]) begin
                outs++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clk); #1;
        end
        iv[k] = 1'b0;
        chk($sformatf("bp%0d_outs", k + 1), outs, 6);
        chk($sformatf("bp%0d_first", k + 1), first, 10);
        chk($sformatf("bp%0d_span", k + 1), last - first, 5);
    endtask

    task automatic flush_test(input int k);
        int cnt = 0;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iv[k] = 1'b1; ia[k] = 8'hC1; ib[k] = 8'hC1;
            irne[k] = 1'b1; itag[k] = 4'(i + 1);
            @(negedge clk);
            chk("fl_fill_ir", 32'(ir[k]), 1);
            @(posedge clk); #1;
        end
        fl[k] = 1'b1;
        itag[k] = 4'hF;
        @(negedge clk);
        chk("fl_ir", 32'(ir[k]), 0);
        @(posedge clk); #1;
        fl[k] = 1'b0;
        iv[k] = 1'b0;
        @(negedge clk);
        chk("fl_ov", 32'(ov[k]), 0);
        ordy[k] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ov[k]) cnt++;
        end
        chk("fl_gone", cnt, 0);
    endtask

    task automatic rst_test(input int k);
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iv[k] = 1'b1; ia[k] = 8'hC1; ib[k] = 8'hC1;
            irne[k] = 1'b1; itag[k] = 4'(i + 9);
            @(posedge clk); #1;
        end
        iv[k] = 1'b0;
        chk("rs_pre_ov", 32'(ov[k]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero_out(k, "rs_async");
        @(negedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        ordy[k] = 1'b1;
        @(negedge clk);
        chk("rs_ir", 32'(ir[k]), 1);
        run_vec(k, 8'hC1, 8'hC1, 1'b1, 8'h92, 1'b1, 1'b1, 1'b0);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rand_traffic(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            iv[k]   = ($urandom_range(0, 3) != 0);
            ia[k]   = pick();
            ib[k]   = pick();
            irne[k] = 1'($urandom);
            itag[k] = 4'($urandom);
            ordy[k] = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ia[k] = '0; ib[k] = '0;
            irne[k] = 1'b0; itag[k] = '0;
            ordy[k] = 1'b1; fl[k] = 1'b0;
        end
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) chk_zero_out(k, "reset");
        #9 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk("reset_ir", 32'(ir[k]), 1);

        run_vec(1, 8'h80, 8'h80, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        run_vec(1, 8'hC1, 8'hC1, 1'b1, 8'h92, 1'b1, 1'b1, 1'b0);
        run_vec(1, 8'hC1, 8'hC1, 1'b0, 8'h91, 1'b1, 1'b1, 1'b0);
        run_vec(1, 8'h88, 8'h88, 1'b1, 8'h90, 1'b0, 1'b1, 1'b0);
        run_vec(1, 8'h92, 8'hE0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
        run_vec(1, 8'h92, 8'hE0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
        run_vec(1, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        run_vec(0, 8'h92, 8'hE0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
        run_vec(2, 8'h88, 8'h88, 1'b1, 8'h90, 1'b0, 1'b1, 1'b0);

        bp_test(0);
        bp_test(1);
        bp_test(2);

        flush_test(1);
        rst_test(1);

        fork
            rand_traffic(0, 400);
            rand_traffic(1, 400);
            rand_traffic(2, 400);
        join

        repeat (10) @(negedge clk);
        chk("drain_s1", g_dut[0].q.size(), 0);
        chk("drain_s2", g_dut[1].q.size(), 0);
        chk("drain_s3", g_dut[2].q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mant_mul_pipe.md
# mant_mul_pipe

Parametrised, pipelined unsigned mantissa multiplier with a valid/ready handshake. It multiplies two W-bit mantissas, normalises the 2W-bit product and applies selectable truncate or round-to-nearest-even (RNE) rounding. It returns a W-bit mantissa, an exponent-increment flag and an inexact flag. It serves as the mantissa datapath of the BF16/FP8 multiply units in the vector/systolic lanes, replacing single-cycle fixed-width trees where timing requires registers.

## Interface
- W, default 8: mantissa width including hidden bit; legal range 4..24.
- STAGES, default 2: pipeline register count, legal 1..3; latency in cycles.
- TAG_W, default 4: width of the sideband tag carried alongside each operation.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous; discards every in-flight operation.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept this cycle.
- in_a, in_b  in  W each  unsigned mantissas.
- in_rne  in  1  1 = RNE, 0 = truncate; travels with the operation.
- in_tag  in  TAG_W  opaque sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_mant  out  W  normalised, rounded mantissa.
- out_exp_inc  out  1  exponent must be incremented by 1.
- out_inexact  out  1  discarded bits nonzero (G|S).
- out_zero  out  1  product was zero.
- out_tag  out  TAG_W  tag of this result.

## Operation
- P = in_a * in_b, 2W bits, exact.
- Normalise:
  - If P[2W-1]=1: ovf=1, M=P[2W-1:W], G=P[W-1], S=|P[W-2:0].
  - Else: ovf=0, M=P[2W-2:W-1], G=P[W-2], S=|P[W-3:0].
- Round:
  - Truncate: up=0.
  - RNE: up = G & (S | M[0]).
  - Mr = M + up, computed at W+1 bits.
- Round carry: if Mr[W]=1, out_mant = 1<<(W-1) and rc=1; otherwise out_mant = Mr[W-1:0] and rc=0.
- out_exp_inc = ovf | rc. Both being 1 is arithmetically impossible, because the top W bits of (2^W-1)^2 are never all ones. No 2-step increment exists.
- out_inexact = G | S, independent of rounding mode.
- out_zero = (P==0); out_mant=0 in that case.
- The block does not require a set hidden bit. Denormal-style inputs are normalised only by the single-bit rule above; the caller handles any larger shift.

## Timing
- Latency is exactly STAGES cycles, measured from the accepting edge (in_valid & in_ready) to the first cycle out_valid is asserted with that result.
- Stage split:
  - STAGES=1: reduce, add, normalise and round in one cycle, then the register.
  - STAGES=2: P registered after reduce/add; normalise and round in stage 2.
  - STAGES=3: sum/carry vectors registered after the 3:2 reduction; carry-propagate add in stage 2; round in stage 3.
- Flow control: each stage register loads when it is empty or its downstream stage is advancing. The last stage advances on out_ready. in_ready = ~valid[0] | advance[0], which is combinational from out_ready through the chain.
- Throughput is 1 operation per cycle while out_ready=1. Holding out_ready=0 fills all STAGES slots, then in_ready=0. No operation is lost or duplicated.
- While out_valid=1 and out_ready=0, all out_* fields hold stable.
- Flush: at the next edge all valid bits clear. Any operation presented in the same cycle is not accepted, and in_ready=0 while flush=1.
- Reset, including mid-operation: all valid bits and data registers go to 0 immediately. Reset values are out_valid=0, out_mant=0, out_exp_inc=0, out_inexact=0, out_zero=0, out_tag=0. in_ready=1 from the first cycle after rst deasserts.

## Structure
- Package mant_mul_pkg holds:
  - typedef round_mode_e {RM_TRUNC, RM_RNE}
  - a localparam for the legal W/STAGES bounds
  - a function computing the reduction-tree level count for W
- Sub-module mant_mul_reduce: a combinational, W-parametrised Wallace 3:2 reduction of the W×W partial products down to sum/carry vectors of 2W bits, built from the shared ha/fa cells.
- The top level holds the optional final add, normalise/round logic and pipeline registers with handshake, plus generate-selected register placement per STAGES.
- Elaboration assertion: W and STAGES are within the legal range.

## Test plan
All scenarios use W=8, STAGES=2 unless noted.
- 0x80×0x80, RNE -> out_mant=0x80, exp_inc=0, inexact=0, zero=0, out_valid 2 cycles after accept.
- 0xC1×0xC1 (P=0x9181), RNE -> mant=0x92, exp_inc=1, inexact=1. Same operands with truncate -> mant=0x91.
- 0x88×0x88 (P=0x4840, tie), RNE -> mant=0x90 (stays even), exp_inc=0, inexact=1.
- 0x92×0xE0 (P=0x7FC0), RNE -> round carry: mant=0x80, exp_inc=1, inexact=1. Truncate -> mant=0xFF, exp_inc=0.
- Backpressure:
  - Stream 6 ops with out_ready=0 -> in_ready drops after 2 accepts.
  - Release out_ready -> results appear in order with matching tags, 1 per cycle, none dropped.
  - Repeat at STAGES=1 and STAGES=3.
- Disruption:
  - Assert flush with 2 ops in flight -> out_valid=0 next cycle, and neither op ever appears.
  - Assert rst mid-stream -> all outputs 0 asynchronously, and the next op after release completes correctly.
- Operand of 0×0xFF -> zero=1, mant=0, inexact=0.
